// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the word-addressed PC, captures the
// combinational instruction-memory word into a small FIFO feeding decode,
// and handles redirects, syscall stalls, window faults and delivery counting.
module fetch_unit #(
  parameter logic [29:0] RESET_PC  = 30'h00100000,
  parameter logic [29:0] IMEM_LAST = 30'h00100100,
  parameter int          DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [29:0]              pc,
  input  logic [31:0]              inst_in,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_inst,
  output logic [29:0]              id_pc,
  input  logic                     redirect_valid,
  input  logic [29:0]              redirect_pc,
  input  logic                     sys_done,
  output logic                     fetch_fault,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              inst_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_SYS_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [29:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          fault_q, fault_d;
  logic [31:0]   icount_q, icount_d;

  logic [31:0]   inst_mem [DEPTH];
  logic [29:0]   pc_mem   [DEPTH];

  logic          push;
  logic          pop;
  logic          in_window;
  logic          is_syscall;
  logic          head_valid;

  assign in_window  = (pc_q >= RESET_PC) && (pc_q <= IMEM_LAST);
  assign is_syscall = (inst_in[31:26] == 6'd0) && (inst_in[5:0] == 6'h0C);
  assign head_valid = (count_q != '0);

  // Next-state, push/pop decisions and FIFO bookkeeping; redirect overrides everything.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fault_d  = fault_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    icount_d = icount_q;
    push     = 1'b0;
    pop      = 1'b0;

    if (redirect_valid) begin
      state_d  = ST_FETCH;
      pc_d     = redirect_pc;
      fault_d  = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      pop = head_valid && id_ready;

      unique case (state_q)
        ST_FETCH: begin
          if (!in_window) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else if ((count_q != FULL_CNT) || pop) begin
            push = 1'b1;
            pc_d = pc_q + 30'd1;
            if (is_syscall) begin
              state_d = ST_SYS_WAIT;
            end
          end
        end
        ST_SYS_WAIT: begin
          if (sys_done) begin
            state_d = ST_FETCH;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        icount_d = icount_q + 32'd1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and status registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
      icount_q <= icount_d;
    end
  end

  // FIFO storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= inst_in;
      pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

  assign pc          = pc_q;
  assign id_valid    = head_valid;
  assign id_inst     = head_valid ? inst_mem[rd_ptr_q] : 32'd0;
  assign id_pc       = head_valid ? pc_mem[rd_ptr_q]   : 30'd0;
  assign fetch_fault = fault_q;
  assign occupancy   = count_q;
  assign inst_count  = icount_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;

  localparam logic [29:0] RESET_PC  = 30'h00100000;
  localparam logic [29:0] IMEM_LAST = 30'h00100100;
  localparam int          DEPTH     = 2;

  logic        clk;
  logic        reset;
  logic [29:0] pc;
  logic [31:0] inst_in;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [29:0] id_pc;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        sys_done;
  logic        fetch_fault;
  logic [1:0]  occupancy;
  logic [31:0] inst_count;

  logic        sys_en;
  logic [29:0] sys_addr;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .IMEM_LAST(IMEM_LAST),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .inst_in       (inst_in),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .sys_done      (sys_done),
    .fetch_fault   (fetch_fault),
    .occupancy     (occupancy),
    .inst_count    (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: 0x20080001, 0x20090002, ... with an optional syscall slot.
  function automatic logic [31:0] imem(input logic [29:0] a, input logic en, input logic [29:0] sa);
    logic [29:0] k;
    if (en && a == sa) return 32'h0000000C;
    k = a - RESET_PC;
    return 32'h20080001 + {2'b00, k} * 32'h00010001;
  endfunction

  always_comb inst_in = imem(pc, sys_en, sys_addr);

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [29:0] pc;
    logic [31:0] inst;
  } ent_t;
  typedef enum {M_FETCH, M_SYS, M_FAULT} mstate_t;

  ent_t        m_q[$];
  logic [29:0] m_pc    = RESET_PC;
  mstate_t     m_state = M_FETCH;
  logic        m_fault = 1'b0;
  logic [31:0] m_cnt   = 32'd0;

  task automatic m_reset();
    m_q.delete();
    m_pc    = RESET_PC;
    m_state = M_FETCH;
    m_fault = 1'b0;
    m_cnt   = 32'd0;
  endtask

  task automatic m_step();
    ent_t e;
    if (redirect_valid) begin
      m_q.delete();
      m_pc    = redirect_pc;
      m_state = M_FETCH;
      m_fault = 1'b0;
      return;
    end
    if (m_q.size() > 0 && id_ready) begin
      void'(m_q.pop_front());
      m_cnt = m_cnt + 32'd1;
    end
    case (m_state)
      M_FETCH: begin
        if (m_pc < RESET_PC || m_pc > IMEM_LAST) begin
          m_state = M_FAULT;
          m_fault = 1'b1;
        end else if (m_q.size() < DEPTH) begin
          e.pc   = m_pc;
          e.inst = imem(m_pc, sys_en, sys_addr);
          m_q.push_back(e);
          m_pc = m_pc + 30'd1;
          if (e.inst[31:26] == 6'd0 && e.inst[5:0] == 6'h0C) m_state = M_SYS;
        end
      end
      M_SYS:   if (sys_done) m_state = M_FETCH;
      default: ;
    endcase
  endtask

  task automatic compare();
    chk("pc", {2'b00, pc}, {2'b00, m_pc});
    chk("occupancy", {30'd0, occupancy}, m_q.size());
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_q.size() > 0});
    chk("id_inst", id_inst, (m_q.size() > 0) ? m_q[0].inst : 32'd0);
    chk("id_pc", {2'b00, id_pc}, (m_q.size() > 0) ? {2'b00, m_q[0].pc} : 32'd0);
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    chk("inst_count", inst_count, m_cnt);
  endtask

  always @(posedge reset) m_reset();

  // Advance the model on each edge, then compare just after the edge.
  always @(posedge clk) begin
    if (reset) m_reset();
    else m_step();
    #1;
    compare();
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] saved_cnt;

  initial begin
    reset = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 30'd0;
    sys_done = 1'b0;
    sys_en = 1'b0;
    sys_addr = 30'd0;

    // Streaming
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #2;
    chk("lit_first_valid", {31'd0, id_valid}, 32'd1);
    chk("lit_first_pc", {2'b00, id_pc}, 32'h00100000);
    chk("lit_first_inst", id_inst, 32'h20080001);
    repeat (4) @(posedge clk); #2;
    chk("lit_stream_count", inst_count, 32'd4);

    // Backpressure
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = RESET_PC; id_ready = 1'b0;
    @(negedge clk); redirect_valid = 1'b0;
    repeat (5) @(posedge clk); #2;
    chk("lit_bp_occ", {30'd0, occupancy}, 32'd2);
    chk("lit_bp_pc", {2'b00, pc}, 32'h00100002);
    @(negedge clk); id_ready = 1'b1;
    @(posedge clk); #2;
    chk("lit_bp_head", {2'b00, id_pc}, 32'h00100001);
    chk("lit_bp_occ_swap", {30'd0, occupancy}, 32'd2);
    repeat (3) @(posedge clk);

    // Redirect with a full FIFO
    @(negedge clk); id_ready = 1'b0;
    repeat (3) @(negedge clk);
    saved_cnt = m_cnt;
    redirect_valid = 1'b1; redirect_pc = 30'h00100010;
    @(posedge clk); #2;
    chk("lit_rd_occ", {30'd0, occupancy}, 32'd0);
    chk("lit_rd_pc", {2'b00, pc}, 32'h00100010);
    chk("lit_rd_count", inst_count, saved_cnt);
    @(negedge clk); redirect_valid = 1'b0; id_ready = 1'b1;
    @(posedge clk); #2;
    chk("lit_rd_head", {2'b00, id_pc}, 32'h00100010);

    // Syscall at 0x00100004
    @(negedge clk); sys_en = 1'b1; sys_addr = 30'h00100004;
    redirect_valid = 1'b1; redirect_pc = RESET_PC;
    @(negedge clk); redirect_valid = 1'b0;
    repeat (8) @(posedge clk); #2;
    chk("lit_sys_pc", {2'b00, pc}, 32'h00100005);
    chk("lit_sys_drained", {30'd0, occupancy}, 32'd0);
    @(negedge clk); sys_done = 1'b1;
    @(negedge clk); sys_done = 1'b0;
    @(posedge clk); #2;
    chk("lit_sys_resume_pc", {2'b00, id_pc}, 32'h00100005);
    chk("lit_sys_next_pc", {2'b00, pc}, 32'h00100006);
    repeat (2) @(posedge clk);

    // Window boundary: last legal word fetches, the next faults
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = IMEM_LAST;
    @(negedge clk); redirect_valid = 1'b0;
    repeat (2) @(posedge clk); #2;
    chk("lit_edge_fault", {31'd0, fetch_fault}, 32'd1);
    chk("lit_edge_pc", {2'b00, pc}, 32'h00100101);

    // Direct redirect out of the window, then recovery
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 30'h00100101;
    @(posedge clk); #2;
    chk("lit_flt_cleared", {31'd0, fetch_fault}, 32'd0);
    @(negedge clk); redirect_valid = 1'b0;
    @(posedge clk); #2;
    chk("lit_flt_set", {31'd0, fetch_fault}, 32'd1);
    repeat (3) @(posedge clk); #2;
    chk("lit_flt_occ", {30'd0, occupancy}, 32'd0);
    chk("lit_flt_pc", {2'b00, pc}, 32'h00100101);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = RESET_PC;
    @(negedge clk); redirect_valid = 1'b0;
    @(posedge clk); #2;
    chk("lit_rec_valid", {31'd0, id_valid}, 32'd1);
    chk("lit_rec_pc", {2'b00, id_pc}, 32'h00100000);
    chk("lit_rec_fault", {31'd0, fetch_fault}, 32'd0);

    // Asynchronous reset between edges with a full FIFO
    @(negedge clk); id_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("lit_ar_pre_occ", {30'd0, occupancy}, 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("lit_ar_occ", {30'd0, occupancy}, 32'd0);
    chk("lit_ar_valid", {31'd0, id_valid}, 32'd0);
    chk("lit_ar_pc", {2'b00, pc}, 32'h00100000);
    chk("lit_ar_idpc", {2'b00, id_pc}, 32'd0);
    chk("lit_ar_inst", id_inst, 32'd0);
    chk("lit_ar_count", inst_count, 32'd0);
    @(negedge clk); reset = 1'b0; id_ready = 1'b1;
    @(posedge clk); #2;
    chk("lit_ar_resume", {2'b00, id_pc}, 32'h00100000);
    repeat (3) @(posedge clk); #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the pipelined MIPS core, directly upstream of the instruction memory and decode. It owns the word-addressed PC and drives it to the combinational instruction memory. It captures the returned word into a small FIFO that feeds decode over a valid/ready handshake. It also handles branch/jump redirects, halts fetch behind a syscall, and counts instructions delivered to decode.

Parameters:
RESET_PC, 30'h00100000, word address loaded on reset (byte address 0x00400000).
IMEM_LAST, 30'h00100100, highest legal word address; the legal window is RESET_PC..IMEM_LAST inclusive.
DEPTH, 2, FIFO entries (power of two, 2 or 4).

Ports:
clk  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-high.
pc  out  30  word address to instruction memory.
inst_in  in  32  instruction word returned combinationally for the current pc.
id_valid  out  1  FIFO head valid.
id_ready  in  1  decode accepts head.
id_inst  out  32  head instruction.
id_pc  out  30  word address of head instruction.
redirect_valid  in  1  branch/jump taken; flush and reload pc.
redirect_pc  in  30  target word address.
sys_done  in  1  one-cycle pulse: outstanding syscall has completed.
fetch_fault  out  1  sticky: pc left the legal window.
occupancy  out  log2(DEPTH)+1  current FIFO entry count.
inst_count  out  32  instructions delivered to decode (feeds the instruction counter).

Behaviour:
- Reset (async): pc=RESET_PC, FIFO empty, id_valid=0, id_inst=0, id_pc=0, occupancy=0, fetch_fault=0, inst_count=0, state=FETCH.
- States:
  - FETCH: normal fetching.
  - SYS_WAIT: a syscall is in flight.
  - FAULT: pc has left the legal window.
- Push condition: state==FETCH, no redirect, pc within window, and (occupancy<DEPTH or a pop happens this cycle). Push enqueues {pc, inst_in} and sets pc<=pc+1.
- Pop: id_valid && id_ready, and no redirect in the same cycle. Each pop increments inst_count (wraps modulo 2^32).
- Syscall detect: on push, if inst_in[31:26]==0 and inst_in[5:0]==6'h0C, state<=SYS_WAIT.
  - pc still advances past the syscall.
  - No further pushes occur until sys_done.
- SYS_WAIT exit: sys_done -> FETCH; the first push happens the cycle after.
- Window fault: in FETCH with pc<RESET_PC or pc>IMEM_LAST -> no push, state<=FAULT, fetch_fault<=1.
  - FIFO keeps draining normally.
- Redirect (highest priority, any state):
  - FIFO cleared (occupancy=0 next cycle); no push or pop that cycle; inst_count unchanged.
  - pc<=redirect_pc; state<=FETCH; fetch_fault<=0.
  - sys_done arriving in the same cycle is ignored (redirect wins).
- Output timing:
  - id_valid, id_inst, id_pc reflect the registered FIFO head; the earliest a pushed word is visible is the next cycle.
  - When empty: id_inst=0, id_pc=0.
- Latency and throughput: one instruction per cycle when decode is always ready. Reset-to-first id_valid is 1 cycle.
- Full FIFO with id_ready=0: pc holds, no push; inst_in is ignored.
- FIFO full with simultaneous pop and push: both occur; occupancy is unchanged.
- Read/write pointers wrap modulo DEPTH.
- pc increment at 30'h3FFFFFFF wraps to 0; the window check then faults.

Test Plan:
- Streaming: reset, imem returns 0x20080001,0x20090002,... and id_ready=1 throughout -> id_valid rises cycle 1 with id_pc=0x00100000. Consecutive pcs follow, one per cycle; inst_count=N after N pops.
- Backpressure: id_ready=0 for 5 cycles -> occupancy saturates at 2, pc frozen at 0x00100002. Release -> in-order delivery 0x00100000, 0x00100001, 0x00100002 with no loss or duplication.
- Redirect: FIFO full, redirect_valid with redirect_pc=0x00100010 -> next cycle occupancy=0, pc=0x00100010. Next id_pc=0x00100010; inst_count is unchanged by the flushed entries.
- Syscall: push 0x0000000C at 0x00100004 -> pushes stop, pc=0x00100005, the syscall drains to decode. sys_done pulse -> 0x00100005 is fetched the following cycle.
- Fault: redirect_pc=0x00100101 -> fetch_fault=1, no pushes, state FAULT. Later redirect to 0x00100000 clears the fault and fetch resumes.
- Async reset mid-stream: reset asserted between clock edges with occupancy=2 -> outputs clear immediately without a clock edge. pc=0x00100000 after deassert.
